// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master drives start and the operands; the slave returns status and results.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] QUOT;
  logic [WIDTH-1:0] REM;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, QUOT, REM, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, QUOT, REM, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one trial subtraction per cycle.
// Divide by zero completes immediately with an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = RW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [RW-1:0]    r_shift;
  logic [SW-1:0]    sum;
  logic [RW-1:0]    trial;
  logic             no_borrow;

  // Trial subtract as add of the inverted divisor with carry-in; carry-out means no borrow.
  always_comb begin
    r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    sum       = {1'b0, r_shift} + {1'b0, ~{1'b0, divisor_q}} + SW'(1);
    no_borrow = sum[SW-1];
    trial     = sum[RW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          divisor_d = bus.divisor;
          if (bus.divisor == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
            r_d     = '0;
            q_d     = bus.dividend;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        q_d   = {q_q[WIDTH-2:0], no_borrow};
        r_d   = no_borrow ? trial : r_shift;
        // Results are published only as the last iteration retires.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = {q_q[WIDTH-2:0], no_borrow};
          rem_d   = no_borrow ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.QUOT     = quot_q;
  assign bus.REM      = rem_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, divide by zero, ignored restarts,
// back-to-back operation and asynchronous reset abort. Inputs change and outputs are sampled on negedge.
module tb_seq_divider;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge of cycle k+1.
  task automatic launch(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = ~dvd;
    bus.divisor  = ~dvs;
  endtask

  // From cycle k+first, step through RUN checking status, then check the done cycle.
  task automatic expect_result(input string tag, input int first,
                               input logic [W-1:0] eq, input logic [W-1:0] er);
    for (int c = first; c <= int'(W); c++) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " done_early"}, 32'(bus.done), 32'd0);
      check({tag, " quot_held"}, 32'(bus.QUOT), 32'(last_q));
      check({tag, " rem_held"}, 32'(bus.REM), 32'(last_r));
      @(negedge clk);
    end
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, " quot"}, 32'(bus.QUOT), 32'(eq));
    check({tag, " rem"}, 32'(bus.REM), 32'(er));
    check({tag, " div_zero"}, 32'(bus.div_zero), 32'd0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    checks       = 0;
    errors       = 0;
    last_q       = '0;
    last_r       = '0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst quot", 32'(bus.QUOT), 32'd0);
    check("rst rem", 32'(bus.REM), 32'd0);
    check("rst dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 100 / 7, then done must drop after one cycle
    launch(8'd100, 8'd7);
    expect_result("t1", 1, 8'd14, 8'd2);
    @(negedge clk);
    check("t1 done_pulse", 32'(bus.done), 32'd0);
    check("t1 idle_busy", 32'(bus.busy), 32'd0);
    check("t1 quot_hold", 32'(bus.QUOT), 32'd14);

    // 2: boundary quotients
    launch(8'd255, 8'd1);
    expect_result("t2a", 1, 8'd255, 8'd0);
    @(negedge clk);
    launch(8'd5, 8'd9);
    expect_result("t2b", 1, 8'd0, 8'd5);
    @(negedge clk);
    launch(8'd255, 8'd255);
    expect_result("t2c", 1, 8'd1, 8'd0);
    @(negedge clk);

    // 3: divide by zero completes in one cycle, then a normal op clears div_zero
    launch(8'd37, 8'd0);
    check("t3 dz done", 32'(bus.done), 32'd1);
    check("t3 dz busy", 32'(bus.busy), 32'd0);
    check("t3 dz quot", 32'(bus.QUOT), 32'hFF);
    check("t3 dz rem", 32'(bus.REM), 32'd37);
    check("t3 dz flag", 32'(bus.div_zero), 32'd1);
    last_q = 8'hFF;
    last_r = 8'd37;
    @(negedge clk);
    check("t3 dz pulse", 32'(bus.done), 32'd0);
    check("t3 dz flag_hold", 32'(bus.div_zero), 32'd1);
    launch(8'd9, 8'd3);
    expect_result("t3b", 1, 8'd3, 8'd0);
    @(negedge clk);

    // 4: start during RUN is ignored
    launch(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    @(negedge clk);
    bus.start    = 1'b0;
    expect_result("t4", 4, 8'd14, 8'd2);
    @(negedge clk);
    check("t4 no_requeue", 32'(bus.busy), 32'd0);
    check("t4 no_requeue_done", 32'(bus.done), 32'd0);

    // 5: back-to-back accept in the done cycle
    launch(8'd100, 8'd7);
    expect_result("t5a", 1, 8'd14, 8'd2);
    launch(8'd200, 8'd13);
    expect_result("t5b", 1, 8'd15, 8'd5);
    @(negedge clk);

    // 6: asynchronous reset mid-RUN aborts with no done
    launch(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 busy", 32'(bus.busy), 32'd0);
    check("t6 done", 32'(bus.done), 32'd0);
    check("t6 quot", 32'(bus.QUOT), 32'd0);
    check("t6 rem", 32'(bus.REM), 32'd0);
    check("t6 dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    for (int c = 0; c < 12; c++) begin
      check("t6 no_done", 32'(bus.done), 32'd0);
      check("t6 no_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    launch(8'd64, 8'd8);
    expect_result("t6b", 1, 8'd8, 8'd0);
    @(negedge clk);

    // Random pairs with nonzero divisor, back-to-back
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      launch(a, b);
      expect_result("rnd", 1, a / b, a % b);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
